// File: rtl/bsg_downstream_rx_buffer.sv
// bsg_downstream_rx_buffer
//   Receive buffer for the downstream off-chip link. IO_W-bit beats land in a
//   DEPTH-entry circular buffer. A packer drains the buffer, gathers RATIO
//   consecutive beats into one CORE_W-bit word and offers it to the core over
//   valid/ready. Credit goes back to the sender as a toggle on io_token_out,
//   one toggle per 2**TOKEN_LG pops.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   io_valid_in     beat present on io_data_in
//   io_data_in      link beat
//   io_token_out    credit toggle to the sender
//   core_valid_out  core_data_out holds a complete word
//   core_data_out   packed word, beat 0 in the low IO_W bits
//   core_ready      core accepts the word when valid & ready
//   full            buffer holds DEPTH entries
//   occupancy       entries currently stored
//   overflow_err    sticky, set when a beat arrives while full
module bsg_downstream_rx_buffer #(
    parameter int IO_W     = 16,
    parameter int CORE_W   = 32,
    parameter int DEPTH    = 64,
    parameter int TOKEN_LG = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       io_valid_in,
    input  logic [IO_W-1:0]            io_data_in,
    output logic                       io_token_out,
    output logic                       core_valid_out,
    output logic [CORE_W-1:0]          core_data_out,
    input  logic                       core_ready,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       overflow_err
);

    localparam int RATIO = CORE_W / IO_W;
    localparam int PW    = $clog2(DEPTH);
    localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [PW:0]   DEPTH_V = (PW+1)'(DEPTH);
    localparam logic [BW-1:0] LAST    = BW'(RATIO - 1);

    typedef enum logic {COLLECT, PRESENT} state_t;

    state_t          state, state_nxt;
    logic [BW-1:0]   beat_idx, beat_idx_nxt;
    logic [PW:0]     wptr, rptr, rptr_inc;
    logic [IO_W-1:0] mem [DEPTH];
    logic [CORE_W-1:0] data_q;
    logic            empty, push, pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign occupancy      = wptr - rptr;
    assign full           = (occupancy == DEPTH_V);
    assign empty          = (wptr == rptr);
    assign push           = io_valid_in & ~full;
    // Empty and full are both taken from the registered pointers, so a beat
    // written this cycle is poppable next cycle at the earliest, and a pop
    // cannot make room for a beat arriving in the same cycle.
    assign pop            = ~empty & ((state == COLLECT) |
                                      ((state == PRESENT) & core_ready));
    assign rptr_inc       = rptr + 1'b1;
    assign core_valid_out = (state == PRESENT);
    assign core_data_out  = data_q;

    always_comb begin
        state_nxt    = state;
        beat_idx_nxt = beat_idx;
        case (state)
            COLLECT: begin
                if (pop) begin
                    if (beat_idx == LAST) begin
                        beat_idx_nxt = '0;
                        state_nxt    = PRESENT;
                    end else begin
                        beat_idx_nxt = beat_idx + 1'b1;
                    end
                end
            end
            PRESENT: begin
                if (core_ready) begin
                    if (!pop) begin
                        state_nxt = COLLECT;
                    end else if (RATIO == 1) begin
                        // Single-beat words: the pop is already a full word.
                        beat_idx_nxt = '0;
                    end else begin
                        // The pop is beat 0 of the next word.
                        state_nxt    = COLLECT;
                        beat_idx_nxt = BW'(1);
                    end
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= COLLECT;
            beat_idx     <= '0;
            wptr         <= '0;
            rptr         <= '0;
            data_q       <= '0;
            io_token_out <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat_idx <= beat_idx_nxt;
            if (push)
                wptr <= wptr + 1'b1;
            if (io_valid_in & full)
                overflow_err <= 1'b1;
            if (pop) begin
                data_q[beat_idx*IO_W +: IO_W] <= mem[rptr[PW-1:0]];
                rptr         <= rptr_inc;
                io_token_out <= rptr_inc[TOKEN_LG];
            end
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[PW-1:0]] <= io_data_in;
    end

endmodule

// File: tb/tb_bsg_downstream_rx_buffer.sv
// Testbench for bsg_downstream_rx_buffer: directed stimulus, expected words
// pushed into a scoreboard queue as beats are driven, a negedge monitor pops
// and compares whenever the DUT hands a word to the core.
module tb_bsg_downstream_rx_buffer;

    localparam int IO_W   = 16;
    localparam int CORE_W = 32;
    localparam int DEPTH  = 64;
    localparam int RATIO  = CORE_W / IO_W;
    localparam int PW     = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              io_valid_in = 1'b0;
    logic [IO_W-1:0]   io_data_in = '0;
    logic              io_token_out;
    logic              core_valid_out;
    logic [CORE_W-1:0] core_data_out;
    logic              core_ready = 1'b0;
    logic              full;
    logic [PW:0]       occupancy;
    logic              overflow_err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [IO_W-1:0]   part_q [$];
    logic [CORE_W-1:0] exp_q  [$];

    always #5 clk = ~clk;

    bsg_downstream_rx_buffer #(
        .IO_W(IO_W), .CORE_W(CORE_W), .DEPTH(DEPTH), .TOKEN_LG(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .io_valid_in(io_valid_in), .io_data_in(io_data_in),
        .io_token_out(io_token_out),
        .core_valid_out(core_valid_out), .core_data_out(core_data_out),
        .core_ready(core_ready),
        .full(full), .occupancy(occupancy), .overflow_err(overflow_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Record an accepted beat; every RATIO beats form one expected word.
    task automatic model_push(input logic [IO_W-1:0] d);
        logic [CORE_W-1:0] w;
        part_q.push_back(d);
        if (part_q.size() == RATIO) begin
            w = '0;
            for (int i = 0; i < RATIO; i++)
                w[i*IO_W +: IO_W] = part_q[i];
            exp_q.push_back(w);
            part_q.delete();
        end
    endtask

    // Called #1 after a rising edge; drives one beat across the next edge.
    task automatic send(input logic [IO_W-1:0] d, input bit accepted);
        io_valid_in = 1'b1;
        io_data_in  = d;
        if (accepted)
            model_push(d);
        @(posedge clk); #1;
        io_valid_in = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        part_q.delete();
        @(negedge clk);
        check("rst_valid", core_valid_out, 0);
        check("rst_data",  core_data_out,  0);
        check("rst_occ",   occupancy,      0);
        check("rst_full",  full,           0);
        check("rst_ovf",   overflow_err,   0);
        check("rst_token", io_token_out,   0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int k;
        core_ready = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #1;
        core_ready = 1'b0;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: a word transfers whenever valid & ready are both high.
    always @(negedge clk) begin
        if (rst_n && core_valid_out && core_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h, no word expected", core_data_out);
            end else begin
                check("word", core_data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cyc;
        logic [IO_W-1:0] d;

        // 1: two beats -> one word, valid appears after the third edge.
        do_reset();
        send(16'h1111, 1'b1);
        send(16'h2222, 1'b1);
        @(negedge clk);
        check("t1_valid_early", core_valid_out, 0);
        @(negedge clk);
        check("t1_valid", core_valid_out, 1);
        check("t1_data_hold", core_data_out, 32'h2222_1111);
        check("t1_token", io_token_out, 0);
        core_ready = 1'b1;
        @(posedge clk); #1;
        core_ready = 1'b0;
        @(negedge clk);
        check("t1_valid_drop", core_valid_out, 0);

        // 2: stream 8 beats; token toggles after pop 4 and pop 8.
        do_reset();
        @(negedge clk);
        core_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                io_valid_in = 1'b1;
                io_data_in  = 16'(16'hA000 + i);
                model_push(io_data_in);
            end else begin
                io_valid_in = 1'b0;
            end
            @(negedge clk);
            // Beat k is popped on edge k+1, so after edge i there were min(i,8) pops.
            check("t2_token", io_token_out, (((i > 8) ? 8 : i) >> 2) & 1);
        end
        io_valid_in = 1'b0;
        drain();

        // 3: fill to full with the core stalled. Two beats first form a word
        // that sits in the output register, so the buffer itself is empty.
        @(posedge clk); #1;
        core_ready = 1'b0;
        send(16'hC000, 1'b1);
        send(16'hC001, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("t3_occ0", occupancy, 0);
        check("t3_present", core_valid_out, 1);
        for (int i = 0; i < 64; i++)
            send(16'(16'hB000 + i), 1'b1);
        @(negedge clk);
        check("t3_full", full, 1);
        check("t3_occ64", occupancy, 64);
        check("t3_ovf_clear", overflow_err, 0);
        @(posedge clk); #1;
        send(16'hDEAD, 1'b0);
        @(negedge clk);
        check("t3_ovf_set", overflow_err, 1);
        check("t3_occ_hold", occupancy, 64);
        repeat (3) @(negedge clk);
        check("t3_ovf_sticky", overflow_err, 1);

        // 4: push and pop in the same cycle while full: push is rejected.
        io_valid_in = 1'b1;
        io_data_in  = 16'hBEEF;
        core_ready  = 1'b1;
        @(posedge clk); #1;
        io_valid_in = 1'b0;
        core_ready  = 1'b0;
        @(negedge clk);
        check("t4_occ63", occupancy, 63);
        check("t4_full", full, 0);
        drain();
        check("t4_ovf_sticky", overflow_err, 1);

        // 5: 300 beats gated by !full with random core_ready; pointers wrap.
        do_reset();
        n = 0;
        cyc = 0;
        while (n < 300 && cyc < 20000) begin
            core_ready = 1'($urandom_range(0, 1));
            if (!full) begin
                d = 16'((n * 16'h0107) ^ 16'h5A5A);
                io_valid_in = 1'b1;
                io_data_in  = d;
                model_push(d);
                n++;
            end else begin
                io_valid_in = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        io_valid_in = 1'b0;
        check("t5_beats_sent", n, 300);
        drain();
        check("t5_ovf", overflow_err, 0);
        check("t5_occ", occupancy, 0);

        // 6: reset after one beat of a word; the partial beat is discarded.
        send(16'h7777, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        send(16'h3333, 1'b1);
        send(16'h4444, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("t6_valid", core_valid_out, 1);
        check("t6_data", core_data_out, 32'h4444_3333);
        drain();

        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
